// File: rtl/trace_trig_sequencer.sv
// -----------------------------------------------------------------------------
// trace_trig_sequencer
//
// Multi-step trigger sequencer. It watches the per-rule match vector from
// trace_trigger, walks a programmable list of (rule mask, occurrence count)
// steps, and after the final step fires a delayed trigger pulse of
// programmable width. The configuration is copied into shadow registers on
// every arm and auto re-arm, so live register writes never disturb a sequence
// that is already running.
//
// Ports
//   TRACECLK, resetn      clock, synchronous active-low reset
//   I_arm / I_disarm      single-cycle control strobes
//   I_rearm               level: re-arm automatically after each pulse
//   I_synchronized        trace stream lock indication
//   I_matching_pattern    per-rule match levels (edges are counted)
//   I_num_steps, I_step_masks, I_step_counts, I_delay, I_pulse_width
//                         sequence configuration (shadowed on arm)
//   O_trig_out            registered trigger pulse
//   O_armed, O_state      state visibility (IDLE=0 WAIT_SYNC=1 MATCH=2
//                         DELAY=3 PULSE=4 DONE=5)
//   O_step                current step index
//   O_trig_count          saturating count of pulses fired since reset
//   O_desync_err          sticky: lock lost while matching
//
// Optional build macro TRACE_TRIG_TIMEOUT_EN adds I_timeout / O_timeout: the
// MATCH state aborts to IDLE when no step advance happens for I_timeout
// cycles (0 disables).
//
// Control strobes: I_arm and I_disarm carry no handshake; each is acted on in
// the cycle it is high. I_disarm always wins, and I_arm is only honoured in
// IDLE or DONE.
// -----------------------------------------------------------------------------
module trace_trig_sequencer #(
  parameter int pMATCH_RULES = 8,
  parameter int pSTEPS       = 4,
  parameter int pCOUNT_WIDTH = 16,
  parameter int pDELAY_WIDTH = 20,
  parameter int pWIDTH_WIDTH = 16
) (
  input  logic                           TRACECLK,
  input  logic                           resetn,
  input  logic                           I_arm,
  input  logic                           I_disarm,
  input  logic                           I_rearm,
  input  logic                           I_synchronized,
  input  logic [pMATCH_RULES-1:0]        I_matching_pattern,
  input  logic [2:0]                     I_num_steps,
  input  logic [pSTEPS*pMATCH_RULES-1:0] I_step_masks,
  input  logic [pSTEPS*pCOUNT_WIDTH-1:0] I_step_counts,
  input  logic [pDELAY_WIDTH-1:0]        I_delay,
  input  logic [pWIDTH_WIDTH-1:0]        I_pulse_width,
`ifdef TRACE_TRIG_TIMEOUT_EN
  input  logic [31:0]                    I_timeout,
  output logic                           O_timeout,
`endif
  output logic                           O_trig_out,
  output logic                           O_armed,
  output logic [2:0]                     O_state,
  output logic [2:0]                     O_step,
  output logic [pCOUNT_WIDTH-1:0]        O_trig_count,
  output logic                           O_desync_err
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_SYNC = 3'd1;
  localparam logic [2:0] S_MATCH     = 3'd2;
  localparam logic [2:0] S_DELAY     = 3'd3;
  localparam logic [2:0] S_PULSE     = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;
  localparam logic [2:0] STEPS3      = 3'(pSTEPS);

  logic [2:0]                     state_q, state_d;
  logic [2:0]                     step_q, step_d;
  logic [pCOUNT_WIDTH-1:0]        evcnt_q, evcnt_d;
  logic [pDELAY_WIDTH-1:0]        delay_cnt_q, delay_cnt_d;
  logic [pWIDTH_WIDTH-1:0]        width_cnt_q, width_cnt_d;
  logic                           trig_out_q, trig_out_d;
  logic [pCOUNT_WIDTH-1:0]        trig_count_q, trig_count_d;
  logic                           desync_err_q, desync_err_d;
  logic [pMATCH_RULES-1:0]        prev_match_q, prev_match_d;
  logic [2:0]                     sh_num_steps_q, sh_num_steps_d;
  logic [pSTEPS*pMATCH_RULES-1:0] sh_masks_q, sh_masks_d;
  logic [pSTEPS*pCOUNT_WIDTH-1:0] sh_counts_q, sh_counts_d;
  logic [pDELAY_WIDTH-1:0]        sh_delay_q, sh_delay_d;
  logic [pWIDTH_WIDTH-1:0]        sh_width_q, sh_width_d;
`ifdef TRACE_TRIG_TIMEOUT_EN
  logic [31:0]                    idle_cnt_q, idle_cnt_d;
  logic                           timeout_q, timeout_d;
  logic [32:0]                    idle_next;
  logic                           timeout_hit;
`endif

  logic [pMATCH_RULES-1:0] cur_mask;
  logic [pCOUNT_WIDTH-1:0] cur_count, count_eff;
  logic [pWIDTH_WIDTH-1:0] width_eff;
  logic [2:0]              num_eff;
  logic                    last_step, match_event, count_hit;
  logic [pCOUNT_WIDTH:0]   evcnt_next;
  logic                    go_pulse, load_shadow;

  // Step-indexed view of the shadowed mask/count.
  always_comb begin
    cur_mask  = '0;
    cur_count = '0;
    for (int k = 0; k < pSTEPS; k++) begin
      if (step_q == 3'(k)) begin
        cur_mask  = sh_masks_q[k*pMATCH_RULES +: pMATCH_RULES];
        cur_count = sh_counts_q[k*pCOUNT_WIDTH +: pCOUNT_WIDTH];
      end
    end
  end

  always_comb begin
    if (sh_num_steps_q == 3'd0)       num_eff = 3'd1;
    else if (sh_num_steps_q > STEPS3) num_eff = STEPS3;
    else                              num_eff = sh_num_steps_q;
  end

  assign last_step   = (step_q == num_eff - 3'd1);
  assign count_eff   = (cur_count == '0) ? pCOUNT_WIDTH'(1) : cur_count;
  assign width_eff   = (sh_width_q == '0) ? pWIDTH_WIDTH'(1) : sh_width_q;
  // Only rising edges qualify, so a rule held high counts exactly once.
  assign match_event = |(I_matching_pattern & ~prev_match_q & cur_mask);
  // One extra bit keeps the >= compare from ever seeing a wrapped count.
  assign evcnt_next  = {1'b0, evcnt_q} + {{pCOUNT_WIDTH{1'b0}}, 1'b1};
  assign count_hit   = (evcnt_next >= {1'b0, count_eff});
`ifdef TRACE_TRIG_TIMEOUT_EN
  assign idle_next   = {1'b0, idle_cnt_q} + 33'd1;
  assign timeout_hit = (I_timeout != 32'd0) && (idle_next >= {1'b0, I_timeout});
`endif

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    evcnt_d      = evcnt_q;
    delay_cnt_d  = delay_cnt_q;
    width_cnt_d  = width_cnt_q;
    trig_out_d   = trig_out_q;
    trig_count_d = trig_count_q;
    desync_err_d = desync_err_q;
    prev_match_d = I_matching_pattern;
    go_pulse     = 1'b0;
    load_shadow  = 1'b0;
`ifdef TRACE_TRIG_TIMEOUT_EN
    idle_cnt_d   = idle_cnt_q;
    timeout_d    = timeout_q;
`endif
    if (I_disarm) begin
      state_d     = S_IDLE;
      step_d      = '0;
      evcnt_d     = '0;
      delay_cnt_d = '0;
      width_cnt_d = '0;
      trig_out_d  = 1'b0;
`ifdef TRACE_TRIG_TIMEOUT_EN
      idle_cnt_d  = '0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (I_arm) begin
            state_d      = S_WAIT_SYNC;
            step_d       = '0;
            evcnt_d      = '0;
            desync_err_d = 1'b0;
            load_shadow  = 1'b1;
`ifdef TRACE_TRIG_TIMEOUT_EN
            timeout_d    = 1'b0;
`endif
          end
        end
        S_WAIT_SYNC: begin
          if (I_synchronized) begin
            state_d = S_MATCH;
`ifdef TRACE_TRIG_TIMEOUT_EN
            idle_cnt_d = '0;
`endif
          end
        end
        S_MATCH: begin
          if (!I_synchronized) begin
            // Lock loss beats any event seen in the same cycle.
            state_d      = S_IDLE;
            desync_err_d = 1'b1;
            step_d       = '0;
            evcnt_d      = '0;
          end else if (match_event && count_hit) begin
            evcnt_d = '0;
            if (last_step) begin
              if (sh_delay_q == '0) begin
                go_pulse = 1'b1;
              end else begin
                state_d     = S_DELAY;
                delay_cnt_d = sh_delay_q - pDELAY_WIDTH'(1);
              end
            end else begin
              step_d = step_q + 3'd1;
`ifdef TRACE_TRIG_TIMEOUT_EN
              idle_cnt_d = '0;
`endif
            end
          end else begin
            if (match_event) evcnt_d = evcnt_next[pCOUNT_WIDTH-1:0];
`ifdef TRACE_TRIG_TIMEOUT_EN
            idle_cnt_d = idle_next[31:0];
            if (timeout_hit) begin
              state_d    = S_IDLE;
              timeout_d  = 1'b1;
              step_d     = '0;
              evcnt_d    = '0;
              idle_cnt_d = '0;
            end
`endif
          end
        end
        S_DELAY: begin
          // Trigger is committed here: lock loss no longer aborts it.
          if (delay_cnt_q == '0) go_pulse = 1'b1;
          else delay_cnt_d = delay_cnt_q - pDELAY_WIDTH'(1);
        end
        S_PULSE: begin
          if (width_cnt_q == '0) begin
            trig_out_d = 1'b0;
            if (I_rearm) begin
              state_d     = I_synchronized ? S_MATCH : S_WAIT_SYNC;
              step_d      = '0;
              evcnt_d     = '0;
              load_shadow = 1'b1;
`ifdef TRACE_TRIG_TIMEOUT_EN
              idle_cnt_d  = '0;
`endif
            end else begin
              state_d = S_DONE;
            end
          end else begin
            width_cnt_d = width_cnt_q - pWIDTH_WIDTH'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (go_pulse) begin
      state_d     = S_PULSE;
      trig_out_d  = 1'b1;
      width_cnt_d = width_eff - pWIDTH_WIDTH'(1);
      if (trig_count_q != {pCOUNT_WIDTH{1'b1}}) trig_count_d = trig_count_q + pCOUNT_WIDTH'(1);
    end

    sh_num_steps_d = load_shadow ? I_num_steps   : sh_num_steps_q;
    sh_masks_d     = load_shadow ? I_step_masks  : sh_masks_q;
    sh_counts_d    = load_shadow ? I_step_counts : sh_counts_q;
    sh_delay_d     = load_shadow ? I_delay       : sh_delay_q;
    sh_width_d     = load_shadow ? I_pulse_width : sh_width_q;
  end

  always_ff @(posedge TRACECLK) begin
    if (!resetn) begin
      state_q        <= S_IDLE;
      step_q         <= '0;
      evcnt_q        <= '0;
      delay_cnt_q    <= '0;
      width_cnt_q    <= '0;
      trig_out_q     <= 1'b0;
      trig_count_q   <= '0;
      desync_err_q   <= 1'b0;
      prev_match_q   <= '0;
      sh_num_steps_q <= '0;
      sh_masks_q     <= '0;
      sh_counts_q    <= '0;
      sh_delay_q     <= '0;
      sh_width_q     <= '0;
`ifdef TRACE_TRIG_TIMEOUT_EN
      idle_cnt_q     <= '0;
      timeout_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      step_q         <= step_d;
      evcnt_q        <= evcnt_d;
      delay_cnt_q    <= delay_cnt_d;
      width_cnt_q    <= width_cnt_d;
      trig_out_q     <= trig_out_d;
      trig_count_q   <= trig_count_d;
      desync_err_q   <= desync_err_d;
      prev_match_q   <= prev_match_d;
      sh_num_steps_q <= sh_num_steps_d;
      sh_masks_q     <= sh_masks_d;
      sh_counts_q    <= sh_counts_d;
      sh_delay_q     <= sh_delay_d;
      sh_width_q     <= sh_width_d;
`ifdef TRACE_TRIG_TIMEOUT_EN
      idle_cnt_q     <= idle_cnt_d;
      timeout_q      <= timeout_d;
`endif
    end
  end

  assign O_trig_out   = trig_out_q;
  assign O_armed      = (state_q == S_WAIT_SYNC) || (state_q == S_MATCH) ||
                        (state_q == S_DELAY) || (state_q == S_PULSE);
  assign O_state      = state_q;
  assign O_step       = step_q;
  assign O_trig_count = trig_count_q;
  assign O_desync_err = desync_err_q;
`ifdef TRACE_TRIG_TIMEOUT_EN
  assign O_timeout    = timeout_q;
`endif

endmodule
